io_port: RTL and testbench
==========================

# io_port

Memory-mapped I/O responder on the CPU's I/O bus. It sits opposite the control unit and decodes IOR/IOW cycles qualified by `iom` and active-low `wen`. It buffers CPU-written words in a TX FIFO toward an external ready/valid sink, and buffers words from an external ready/valid source in an RX FIFO for CPU reads. Read data feeds the datapath's `md = 2'b10` input.

## Interface
- `DEPTH`, 4: entries per FIFO; power of two, ≥ 2.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `addr_in` in 16: bus address; only `[1:0]` decoded.
- `data_in` in 16: CPU write data (register B bus).
- `iom_in` in 1: I/O cycle qualifier from the CU.
- `wen_in` in 1: active-low write enable from the CU.
- `data_out` out 16: read data to the CPU.
- `tx_data_out` out 16: TX FIFO head.
- `tx_valid_out` out 1: TX FIFO non-empty.
- `tx_ready_in` in 1: external sink accepts.
- `rx_data_in` in 16: external source word.
- `rx_valid_in` in 1: external source offers a word.
- `rx_ready_out` out 1: RX FIFO not full.

## Operation
- Decoded by `iom_in` and `wen_in` (`wen_in` = 0 means write):
  - `iom_in`=1, `wen_in`=0: CPU write.
  - `iom_in`=1, `wen_in`=1: CPU read.
  - `iom_in`=0: no access; `data_out` = 0.
- Register map by `addr_in[1:0]`:
  - 0 DATA
    - Write pushes `data_in` to TX. Full TX: word dropped, `tx_ovf` set.
    - Read returns RX head and pops at the edge. Empty RX: returns 0, no pop, `rx_unf` set.
  - 1 STATUS, read-only, writes ignored.
    - Bit layout `{10'b0, rx_unf, tx_ovf, rx_full, rx_empty, tx_full, tx_empty}`.
    - A read clears `rx_unf` and `tx_ovf` at that edge and returns their pre-clear values.
  - 2 CTRL, write-only, reads 0.
    - `data_in[0]`=1 flushes TX; `data_in[1]`=1 flushes RX.
    - A flush also clears the sticky flags of that FIFO.
  - 3 reserved: reads 0, writes ignored.
- TX pop: at an edge with `tx_valid_out`=1 and `tx_ready_in`=1.
- RX push: at an edge with `rx_valid_in`=1 and `rx_ready_out`=1.
- Simultaneous push and pop on one FIFO:
  - Both take effect; count unchanged.
  - When full, a push with a same-edge pop is still accepted (no overflow).
  - When empty, a read pop with a same-edge push returns 0 with `rx_unf` set; the pushed word is stored.
- Flush plus same-edge push: the flush wins, the FIFO ends empty, the push is discarded without setting `tx_ovf`.
- Pointers wrap modulo `DEPTH`. Count is `$clog2(DEPTH)+1` bits; full when count = `DEPTH`.

## Timing
- Reset values: both FIFOs empty, flags 0.
  - `tx_valid_out`=0, `tx_data_out`=0, `rx_ready_out`=1, `data_out`=0.
- `data_out` is combinational from address decode and registered state. It is valid in the same EX0 cycle, so the CU's register write captures it at that edge.
- All state updates happen on the rising edge.
- `tx_valid_out`, `tx_data_out` and `rx_ready_out` are driven from registered state only (no combinational path from `tx_ready_in` or `rx_valid_in`).
- Latency:
  - CPU write to `tx_valid_out`: 1 cycle.
  - External RX push to CPU-readable data: 1 cycle.
- Reset asserted mid-transfer discards all FIFO contents immediately (asynchronous).
- Without `iom_in` no state changes except external-side push/pop. Its absence in INF/RST/HLT cycles guarantees no spurious pops.

## Structure
- Add to the shared CPU package:
  - Address constants `IO_DATA`=2'd0, `IO_STAT`=2'd1, `IO_CTRL`=2'd2.
  - Status bit indices.
- One sub-module, `io_fifo`, instantiated twice (TX, RX).
  - Parameters `DEPTH` and width 16.
  - Ports: `push`, `pop`, `flush`, `din`, `dout` (head), `full`, `empty`.
  - Push-when-full with simultaneous pop is handled inside it.
- Top level holds the decode, the sticky flags and the `data_out` mux.

## Test plan
- After reset: read STATUS → `16'h0005`; `rx_ready_out`=1; `tx_valid_out`=0.
- Write DATA `16'h1234` then `16'hABCD` with `tx_ready_in`=0 → `tx_valid_out`=1, `tx_data_out`=`16'h1234`. Raise `tx_ready_in` for 2 cycles → sees `16'hABCD`, then `tx_valid_out`=0.
- Five writes with `tx_ready_in`=0 → STATUS reads `16'h0016` (`tx_ovf`, `tx_full`, `rx_empty`). A second STATUS read → `16'h0006`. Drained TX order is the first four words.
- External source pushes `16'h0001`..`16'h0004` → `rx_ready_out`=0 after the 4th. DATA reads return 1,2,3,4. A 5th read returns 0 and sets `rx_unf`.
- Full TX with `tx_ready_in`=1 and a CPU write in the same cycle → no `tx_ovf`, count stays 4, new word at the tail.
- Write CTRL `16'h0003` with both FIFOs holding data → both empty the next cycle, STATUS = `16'h0005`. Assert `rst_n`=0 mid-stream → outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/io_port_pkg.sv
// Shared CPU package: I/O register addresses and STATUS bit positions.
package io_port_pkg;

  localparam int unsigned IO_W = 16;

  localparam logic [1:0] IO_DATA = 2'd0;
  localparam logic [1:0] IO_STAT = 2'd1;
  localparam logic [1:0] IO_CTRL = 2'd2;

  localparam int unsigned ST_TX_EMPTY = 0;
  localparam int unsigned ST_TX_FULL  = 1;
  localparam int unsigned ST_RX_EMPTY = 2;
  localparam int unsigned ST_RX_FULL  = 3;
  localparam int unsigned ST_TX_OVF   = 4;
  localparam int unsigned ST_RX_UNF   = 5;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted when a pop
// happens on the same edge.
module io_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/io_port.sv
// Memory-mapped I/O responder: bus decode, sticky error flags and read mux
// around a TX and an RX FIFO.
module io_port
  import io_port_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     addr_in,
  input  logic [15:0]     data_in,
  input  logic            iom_in,
  input  logic            wen_in,
  output logic [15:0]     data_out,
  output logic [15:0]     tx_data_out,
  output logic            tx_valid_out,
  input  logic            tx_ready_in,
  input  logic [15:0]     rx_data_in,
  input  logic            rx_valid_in,
  output logic            rx_ready_out
);

  logic        io_wr, io_rd;
  logic        tx_push, tx_flush, tx_full, tx_empty;
  logic        rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [15:0] rx_head;
  logic        tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
  logic        stat_rd;
  logic        unused_addr;

  assign unused_addr = ^addr_in[15:2];

  assign io_wr    = iom_in && !wen_in;
  assign io_rd    = iom_in && wen_in;
  assign tx_push  = io_wr && (addr_in[1:0] == IO_DATA);
  assign tx_flush = io_wr && (addr_in[1:0] == IO_CTRL) && data_in[0];
  assign rx_flush = io_wr && (addr_in[1:0] == IO_CTRL) && data_in[1];
  assign rx_pop   = io_rd && (addr_in[1:0] == IO_DATA);
  assign stat_rd  = io_rd && (addr_in[1:0] == IO_STAT);
  assign rx_push  = rx_valid_in && !rx_full;

  assign tx_valid_out = !tx_empty;
  assign rx_ready_out = !rx_full;

  io_fifo #(.DEPTH(DEPTH), .WIDTH(IO_W)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_ready_in),
    .flush (tx_flush),
    .din   (data_in),
    .dout  (tx_data_out),
    .full  (tx_full),
    .empty (tx_empty)
  );

  io_fifo #(.DEPTH(DEPTH), .WIDTH(IO_W)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (rx_data_in),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // A full TX only overflows when the sink is not draining on the same edge.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_unf_d = rx_unf_q;
    if (stat_rd) begin
      tx_ovf_d = 1'b0;
      rx_unf_d = 1'b0;
    end
    if (tx_flush) tx_ovf_d = 1'b0;
    else if (tx_push && tx_full && !tx_ready_in) tx_ovf_d = 1'b1;
    if (rx_flush) rx_unf_d = 1'b0;
    else if (rx_pop && rx_empty) rx_unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
    end
  end

  always_comb begin
    data_out = '0;
    if (io_rd) begin
      case (addr_in[1:0])
        IO_DATA: data_out = rx_empty ? 16'h0000 : rx_head;
        IO_STAT: begin
          data_out[ST_TX_EMPTY] = tx_empty;
          data_out[ST_TX_FULL]  = tx_full;
          data_out[ST_RX_EMPTY] = rx_empty;
          data_out[ST_RX_FULL]  = rx_full;
          data_out[ST_TX_OVF]   = tx_ovf_q;
          data_out[ST_RX_UNF]   = rx_unf_q;
        end
        default: data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port.sv
// Scoreboard bench for io_port: queue-based reference model, directed
// scenarios followed by randomized bus and stream traffic.
module tb_io_port;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr_in = '0, data_in = '0, rx_data_in = '0;
  logic        iom_in = 1'b0, wen_in = 1'b1, tx_ready_in = 1'b0, rx_valid_in = 1'b0;
  logic [15:0] data_out, tx_data_out;
  logic        tx_valid_out, rx_ready_out;

  io_port #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr_in      (addr_in),
    .data_in      (data_in),
    .iom_in       (iom_in),
    .wen_in       (wen_in),
    .data_out     (data_out),
    .tx_data_out  (tx_data_out),
    .tx_valid_out (tx_valid_out),
    .tx_ready_in  (tx_ready_in),
    .rx_data_in   (rx_data_in),
    .rx_valid_in  (rx_valid_in),
    .rx_ready_out (rx_ready_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        txv;
    logic [15:0] txd;
    logic        rxr;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_tx[$];
  logic [15:0] m_rx[$];
  bit          m_ovf = 1'b0, m_unf = 1'b0;
  bit          mon_en = 1'b0;
  int unsigned n_cmp = 0, n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = '0;
    s[0] = (m_tx.size() == 0);
    s[1] = (m_tx.size() == DEPTH);
    s[2] = (m_rx.size() == 0);
    s[3] = (m_rx.size() == DEPTH);
    s[4] = m_ovf;
    s[5] = m_unf;
    return s;
  endfunction

  // Drives one bus cycle, records the expected outputs, then advances the model.
  task automatic step(input bit iom, input bit wen, input logic [1:0] a, input logic [15:0] d,
                      input bit txr, input bit rxv, input logic [15:0] rxd);
    exp_t e;
    bit   wr, rd, txpop, rxpush;
    @(posedge clk);
    #1;
    iom_in = iom; wen_in = wen; addr_in = {14'h0, a}; data_in = d;
    tx_ready_in = txr; rx_valid_in = rxv; rx_data_in = rxd;
    wr = iom && !wen;
    rd = iom && wen;
    e.data = '0;
    if (rd && a == 2'd0) e.data = (m_rx.size() != 0) ? m_rx[0] : 16'h0000;
    if (rd && a == 2'd1) e.data = m_status();
    e.txv = (m_tx.size() != 0);
    e.txd = e.txv ? m_tx[0] : 16'h0000;
    e.rxr = (m_rx.size() < DEPTH);
    sb_q.push_back(e);
    txpop  = e.txv && txr;
    rxpush = rxv && e.rxr;
    if (rd && a == 2'd1) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (wr && a == 2'd2 && d[0]) begin
      m_tx.delete();
      m_ovf = 1'b0;
    end else begin
      if (txpop) void'(m_tx.pop_front());
      if (wr && a == 2'd0) begin
        if (m_tx.size() < DEPTH) m_tx.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    if (wr && a == 2'd2 && d[1]) begin
      m_rx.delete();
      m_unf = 1'b0;
    end else begin
      if (rd && a == 2'd0) begin
        if (m_rx.size() != 0) void'(m_rx.pop_front());
        else m_unf = 1'b1;
      end
      if (rxpush) m_rx.push_back(rxd);
    end
  endtask

  task automatic idle(input bit txr);
    step(1'b0, 1'b1, 2'd0, 16'h0, txr, 1'b0, 16'h0);
  endtask

  // Spot check of data_out against a literal in the cycle just stepped.
  task automatic expect_now(input string name, input logic [15:0] v);
    @(negedge clk);
    #1;
    check(name, data_out, v);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1;
    iom_in = 1'b0; tx_ready_in = 1'b0; rx_valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_tx_valid", {15'h0, tx_valid_out}, 16'h0000);
    check("rst_tx_data", tx_data_out, 16'h0000);
    check("rst_rx_ready", {15'h0, rx_ready_out}, 16'h0001);
    check("rst_data_out", data_out, 16'h0000);
    m_tx.delete(); m_rx.delete();
    m_ovf = 1'b0; m_unf = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard_empty: got no entry expected one at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        check("data_out", data_out, e.data);
        check("tx_valid", {15'h0, tx_valid_out}, {15'h0, e.txv});
        check("rx_ready", {15'h0, rx_ready_out}, {15'h0, e.rxr});
        if (e.txv) check("tx_data", tx_data_out, e.txd);
      end
    end
  end

  initial begin
    logic [15:0] d;
    logic [1:0]  a;
    #12;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    step(1'b1, 1'b1, 2'd1, 16'h0, 1'b0, 1'b0, 16'h0);
    expect_now("stat_after_reset", 16'h0005);

    step(1'b1, 1'b0, 2'd0, 16'h1234, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 2'd0, 16'hABCD, 1'b0, 1'b0, 16'h0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'd0, 16'h1100 + 16'(i), 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 2'd1, 16'h0, 1'b0, 1'b0, 16'h0);
    expect_now("stat_ovf", 16'h0016);
    step(1'b1, 1'b1, 2'd1, 16'h0, 1'b0, 1'b0, 16'h0);
    expect_now("stat_ovf_cleared", 16'h0006);
    for (int i = 0; i < 5; i++) idle(1'b1);

    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 2'd0, 16'h0, 1'b0, 1'b1, 16'(i));
    idle(1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b1, 2'd0, 16'h0, 1'b0, 1'b0, 16'h0);
      expect_now("rx_read_seq", (i <= 4) ? 16'(i) : 16'h0000);
    end
    step(1'b1, 1'b1, 2'd1, 16'h0, 1'b0, 1'b0, 16'h0);
    expect_now("stat_unf", 16'h0025);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'd0, 16'h2200 + 16'(i), 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 2'd0, 16'h22FF, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 2'd1, 16'h0, 1'b0, 1'b0, 16'h0);
    expect_now("stat_full_no_ovf", 16'h0006);
    for (int i = 0; i < 5; i++) idle(1'b1);

    step(1'b1, 1'b0, 2'd0, 16'h3333, 1'b0, 1'b1, 16'h4444);
    step(1'b1, 1'b0, 2'd2, 16'h0003, 1'b0, 1'b1, 16'h5555);
    step(1'b1, 1'b1, 2'd1, 16'h0, 1'b0, 1'b0, 16'h0);
    expect_now("stat_after_flush", 16'h0005);

    for (int i = 0; i < 2000; i++) begin
      a = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      if (a == 2'd2 && $urandom_range(0, 7) != 0) d[1:0] = 2'b00;
      step($urandom_range(0, 3) != 0, 1'($urandom), a, d,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0, 16'($urandom));
      if (i == 1000) begin
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 2'd0, 16'h7700 + 16'(k), 1'b0, 1'b1, 16'h8800);
        async_reset();
      end
    end

    @(negedge clk);
    #2;
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
